lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store execution unit that consumes the 5-bit lsunit control bus produced by the instruction decoder. It drives a request/acknowledge data-memory port and performs byte-lane alignment, write-data replication and load sign/zero extension. It stalls the single-cycle core while an access is outstanding. It sits between the ALU result and rs2 operands on one side and the data memory on the other, and feeds load data to the writeback mux.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for mem_ack before aborting with a bus error.
- TW, 5: width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- lsunit  in  5  decoder bus, fields as follows:
  - [4] valid load/store.
  - [3] 1 = store, 0 = load.
  - [2:0] funct3.
- addr  in  32  effective address (ALU result).
- st_data  in  32  rs2 value for stores.
- stall  out  1  holds PC/regfile write while the access is in progress.
- ld_data  out  32  extended load result, valid while ld_valid = 1.
- ld_valid  out  1  one-cycle pulse, load data ready.
- misalign  out  1  one-cycle pulse, misaligned or illegal funct3 access.
- bus_err  out  1  one-cycle pulse, mem_ack timeout.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address; {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  memory completes the request this cycle.
- mem_rdata  in  32  read word, sampled when mem_ack = 1.

Behaviour:

Reset and registers
- Clock and reset: single clock; reset is synchronous, active-low.
- Reset (rst_n = 0 at a clk edge): state = IDLE. The following are all 0: mem_req, mem_we, mem_addr, mem_be, mem_wdata, ld_data, ld_valid, misalign, bus_err, timeout counter.
- Reset overrides everything, including mid-BUSY. mem_req drops on the next edge; a later mem_ack is ignored.
- All mem_* outputs, ld_data and the pulse flags are registered.
- stall is combinational: stall = (state == IDLE && start) || state == BUSY.
  - start = lsunit[4] && legal && aligned.

Legality
- Legal loads: funct3 in {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
- Legal stores: funct3 in {000 SB, 001 SH, 010 SW}.
- Alignment: half accesses require addr[0] = 0; word accesses require addr[1:0] = 00.

States
- IDLE:
  - lsunit[4] = 0: stay in IDLE.
  - lsunit[4] = 1 and illegal or misaligned: misalign <= 1 for one cycle, no request, stall = 0, stay in IDLE.
  - start: latch the access and go to BUSY. Latched values:
    - mem_req <= 1, mem_we <= lsunit[3], mem_addr, mem_be, mem_wdata.
    - addr[1:0] and funct3 kept internally.
    - Counter cleared.
- BUSY:
  - Request fields are held stable.
  - Counter increments each cycle.
  - On mem_ack: mem_req <= 0. For a load, ld_data <= extract(mem_rdata) and ld_valid <= 1. Go to DONE.
  - Counter reaching TIMEOUT without ack: mem_req <= 0, bus_err <= 1, ld_data <= 0. Go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - stall = 0; the instruction retires at the end of this cycle.
  - Pulses clear on the following edge; the next state is always IDLE.
  - lsunit is not sampled in DONE, so the retiring instruction is never re-issued.
- Latency from issue to retire: stall is high for 1 + N cycles, where N is the number of cycles mem_req is high. The DONE cycle follows.

Store byte enables and data
- SB: be = 4'b0001 << addr[1:0]; wdata = {4{st_data[7:0]}}.
- SH: be = addr[1] ? 1100 : 0011; wdata = {2{st_data[15:0]}}.
- SW: be = 1111; wdata = st_data.
- For loads, mem_be is derived the same way and mem_wdata = 0.

Load extraction
- Byte = mem_rdata[8*a+7 : 8*a], where a = addr[1:0].
- Half = mem_rdata[16*a1+15 : 16*a1], where a1 = addr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.

Test Plan:
1. SW at addr 0x100, st_data 0xDEADBEEF, ack after 2 cycles -> mem_req held 2 cycles with addr 0x100, be 1111, wdata DEADBEEF, we = 1; stall high 3 cycles; DONE once; no ld_valid.
2. LB at addr 0x203, mem_rdata 0x80FF_1234, immediate ack -> ld_data 0xFFFFFF80, ld_valid pulse. LBU at the same address -> 0x00000080.
3. SH at addr 0x12, st_data 0x0000ABCD -> be 1100, wdata 0xABCDABCD. LH at 0x11 -> misalign pulse, mem_req stays 0, stall 0.
4. LW at 0x40 with mem_ack never asserted, TIMEOUT = 16 -> mem_req high exactly 16 cycles, bus_err pulse, ld_data 0, state returns to IDLE.
5. rst_n = 0 during BUSY of an LHU -> mem_req 0 on the next edge; ack asserted afterwards produces no ld_valid; a new SB at 0x1 then issues with be 0010.
6. Back-to-back LW 0x0 then SW 0x4, each acked after 1 cycle -> the second request is issued only in the IDLE cycle after DONE, and each instruction is issued exactly once.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Request/acknowledge data-memory port used by the load/store unit.
//
// Signals:
//   mem_req    request pending; held until the cycle mem_ack is seen
//   mem_we     1 = write, 0 = read
//   mem_addr   word-aligned address
//   mem_be     byte-lane enables
//   mem_wdata  lane-replicated store data
//   mem_ack    memory completes the request this cycle
//   mem_rdata  read word, meaningful when mem_ack = 1
//
// Modports:
//   master  the load/store unit (drives the request side)
//   slave   the data memory (drives ack and read data)
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_be,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_be,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store execution unit. Decodes the 5-bit lsunit bus from the
// instruction decoder, issues one request on the data-memory port, aligns
// byte lanes and replicates store data, sign/zero-extends load data, and
// stalls the single-cycle core while the access is outstanding. A request
// that is not acknowledged within TIMEOUT cycles is aborted with bus_err.
//
// Ports:
//   clk       core clock, rising edge
//   rst_n     synchronous active-low reset
//   lsunit    [4] valid, [3] 1 = store / 0 = load, [2:0] funct3
//   addr      effective address from the ALU
//   st_data   rs2 value for stores
//   stall     holds PC/regfile write while the access is in progress
//   ld_data   extended load result, valid while ld_valid = 1
//   ld_valid  one-cycle pulse, load data ready
//   misalign  one-cycle pulse, misaligned or illegal funct3 access
//   bus_err   one-cycle pulse, mem_ack timeout
//   mem       data-memory port (master side)
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
   parameter int TIMEOUT = 16,
   parameter int TW      = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4:0]            lsunit,
   input  logic [31:0]           addr,
   input  logic [31:0]           st_data,
   output logic                  stall,
   output logic [31:0]           ld_data,
   output logic                  ld_valid,
   output logic                  misalign,
   output logic                  bus_err,
   lsu_mem_ctrl_if.master        mem
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic          req_q, req_d;
   logic          we_q, we_d;
   logic [31:0]   addr_q, addr_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   ld_data_q, ld_data_d;
   logic          ld_valid_q, ld_valid_d;
   logic          misalign_q, misalign_d;
   logic          bus_err_q, bus_err_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [1:0]    lane_q, lane_d;
   logic [2:0]    f3_q, f3_d;

   logic [2:0]    f3;
   logic          is_store;
   logic          legal;
   logic          aligned;
   logic          start;
   logic [3:0]    issue_be;
   logic [31:0]   issue_wdata;
   logic [7:0]    rd_byte;
   logic [15:0]   rd_half;
   logic [31:0]   ld_ext;

   assign f3       = lsunit[2:0];
   assign is_store = lsunit[3];

   // Decode the access: which funct3 codes are legal for a load versus a
   // store, and whether the address is naturally aligned for the size.
   // funct3[1:0] encodes the size (byte, half, word) for both directions.
   always_comb begin
      legal   = 1'b0;
      aligned = 1'b0;
      case (f3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !is_store;
         default:                legal = 1'b0;
      endcase
      case (f3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = !addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   assign start = lsunit[4] && legal && aligned;

   // Byte enables and replicated write data for the access being issued.
   // Replication lets the memory pick any enabled lane without a shifter.
   // Loads use the same enables but never put data on the write bus.
   always_comb begin
      issue_be    = 4'b1111;
      issue_wdata = 32'd0;
      case (f3[1:0])
         2'b00: begin
            issue_be    = 4'b0001 << addr[1:0];
            issue_wdata = {4{st_data[7:0]}};
         end
         2'b01: begin
            issue_be    = addr[1] ? 4'b1100 : 4'b0011;
            issue_wdata = {2{st_data[15:0]}};
         end
         default: begin
            issue_be    = 4'b1111;
            issue_wdata = st_data;
         end
      endcase
      if (!is_store) begin
         issue_wdata = 32'd0;
      end
   end

   // Pick the addressed byte or half out of the returned word using the
   // address bits latched at issue, then extend according to funct3.
   always_comb begin
      rd_byte = 8'd0;
      case (lane_q)
         2'd0: rd_byte = mem.mem_rdata[7:0];
         2'd1: rd_byte = mem.mem_rdata[15:8];
         2'd2: rd_byte = mem.mem_rdata[23:16];
         2'd3: rd_byte = mem.mem_rdata[31:24];
         default: rd_byte = 8'd0;
      endcase
      rd_half = lane_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  ld_ext = {24'd0, rd_byte};
         3'b101:  ld_ext = {16'd0, rd_half};
         default: ld_ext = mem.mem_rdata;
      endcase
   end

   // Next-state and next-output logic. Everything defaults to holding its
   // value except the pulse flags, which default low so they last exactly
   // one cycle. lsunit is only looked at in IDLE, so the instruction that
   // is retiring during DONE cannot be issued a second time. When ack and
   // the last timeout cycle coincide the ack branch is taken first.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      ld_data_d  = ld_data_q;
      ld_valid_d = 1'b0;
      misalign_d = 1'b0;
      bus_err_d  = 1'b0;
      cnt_d      = cnt_q;
      lane_d     = lane_q;
      f3_d       = f3_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = BUSY;
               req_d   = 1'b1;
               we_d    = is_store;
               addr_d  = {addr[31:2], 2'b00};
               be_d    = issue_be;
               wdata_d = issue_wdata;
               lane_d  = addr[1:0];
               f3_d    = f3;
               cnt_d   = '0;
            end else if (lsunit[4]) begin
               misalign_d = 1'b1;
            end
         end
         BUSY: begin
            cnt_d = cnt_q + TW'(1);
            if (mem.mem_ack) begin
               req_d   = 1'b0;
               state_d = DONE;
               if (!we_q) begin
                  ld_data_d  = ld_ext;
                  ld_valid_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               ld_data_d = 32'd0;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers. Reset is synchronous and takes priority
   // over everything, including an access in flight, so a late ack after
   // reset finds the unit in IDLE and is ignored.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= 32'd0;
         be_q       <= 4'd0;
         wdata_q    <= 32'd0;
         ld_data_q  <= 32'd0;
         ld_valid_q <= 1'b0;
         misalign_q <= 1'b0;
         bus_err_q  <= 1'b0;
         cnt_q      <= '0;
         lane_q     <= 2'd0;
         f3_q       <= 3'd0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         ld_data_q  <= ld_data_d;
         ld_valid_q <= ld_valid_d;
         misalign_q <= misalign_d;
         bus_err_q  <= bus_err_d;
         cnt_q      <= cnt_d;
         lane_q     <= lane_d;
         f3_q       <= f3_d;
      end
   end

   // Stall is combinational so the core freezes in the very cycle a legal
   // access is presented, and stays frozen until the access completes.
   assign stall = ((state_q == IDLE) && start) || (state_q == BUSY);

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_be    = be_q;
   assign mem.mem_wdata = wdata_q;
   assign ld_data       = ld_data_q;
   assign ld_valid      = ld_valid_q;
   assign misalign      = misalign_q;
   assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Self-checking bench for lsu_mem_ctrl. A driver issues directed and random
// load/store instructions; a reference model works out from the access
// rules what the memory port and result flags should show and queues those
// events; a monitor pops and compares whenever the DUT presents a new
// request, ld_valid, misalign or bus_err. A memory responder acks after a
// per-instruction delay (or never).
// ---------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

   localparam int TIMEOUT = 16;
   localparam int K_REQ   = 0;
   localparam int K_LOAD  = 1;
   localparam int K_MIS   = 2;
   localparam int K_BERR  = 3;

   typedef struct {
      int          kind;
      logic        we;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  lsunit = 5'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] st_data = 32'd0;
   logic        stall;
   logic [31:0] ld_data;
   logic        ld_valid;
   logic        misalign;
   logic        bus_err;

   int          vectors = 0;
   int          miscompares = 0;
   exp_t        sb[$];

   int          resp_delay = 0;
   logic [31:0] resp_data = 32'd0;
   logic        extra_ack = 1'b0;
   int          req_cycles = 0;

   lsu_mem_ctrl_if mem ();

   lsu_mem_ctrl #(.TIMEOUT(TIMEOUT), .TW(5)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .lsunit   (lsunit),
      .addr     (addr),
      .st_data  (st_data),
      .stall    (stall),
      .ld_data  (ld_data),
      .ld_valid (ld_valid),
      .misalign (misalign),
      .bus_err  (bus_err),
      .mem      (mem)
   );

   // Free-running core clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports misses.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, want, $time);
      end
   endtask

   // Reference model: derives the expected memory request and result from
   // size/sign rules with plain arithmetic and queues them in issue order.
   // Returns the number of cycles stall should be high.
   task automatic modelIssue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input logic [31:0] rd, input int delay,
                             output int exp_stall);
      exp_t e;
      int   size;
      int   lane;
      bit   legal;
      bit   aligned;
      logic [31:0] val;
      size    = 1 << f3[1:0];
      lane    = int'(a[1:0]);
      legal   = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      aligned = (size <= 4) && ((lane % size) == 0);
      e.kind  = K_MIS;
      e.we    = 1'b0;
      e.a     = 32'd0;
      e.be    = 4'd0;
      e.wdata = 32'd0;
      e.data  = 32'd0;
      if (!(legal && aligned)) begin
         sb.push_back(e);
         exp_stall = 0;
      end else begin
         e.kind = K_REQ;
         e.we   = st;
         e.a    = a & 32'hFFFF_FFFC;
         e.be   = 4'(((1 << size) - 1) << lane);
         for (int i = 0; i < 4; i++) begin
            e.wdata[8*i +: 8] = st ? sd[8*(i % size) +: 8] : 8'd0;
         end
         sb.push_back(e);
         if (delay < 0 || delay >= TIMEOUT) begin
            e.kind = K_BERR;
            e.data = 32'd0;
            sb.push_back(e);
            exp_stall = 1 + TIMEOUT;
         end else begin
            if (!st) begin
               val = rd >> (8 * lane);
               if (size == 1) begin
                  val = val & 32'h0000_00FF;
                  if (!f3[2] && val[7]) val = val | 32'hFFFF_FF00;
               end else if (size == 2) begin
                  val = val & 32'h0000_FFFF;
                  if (!f3[2] && val[15]) val = val | 32'hFFFF_0000;
               end
               e.kind = K_LOAD;
               e.data = val;
               sb.push_back(e);
            end
            exp_stall = delay + 2;
         end
      end
   endtask

   // Drives one instruction, holds it while stall is high, then checks the
   // number of stalled cycles against the model before moving on.
   task automatic applyStimulus(input logic [4:0] lu, input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, input int delay);
      int  exp_stall;
      int  n;
      bit  done;
      resp_delay = delay;
      resp_data  = rd;
      exp_stall  = 0;
      if (lu[4]) modelIssue(lu[3], lu[2:0], a, sd, rd, delay, exp_stall);
      lsunit  = lu;
      addr    = a;
      st_data = sd;
      n       = 0;
      done    = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
         end else begin
            n++;
            @(posedge clk);
            #1;
         end
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL stall_bound: stall still high after 64 cycles, want low");
      end
      checkOutput("stall_cycles", 32'(n), 32'(exp_stall));
      @(posedge clk);
      #1;
      lsunit = 5'd0;
   endtask

   // Memory responder: acks in the (resp_delay+1)-th request cycle, never
   // when resp_delay is negative; extra_ack forces a stray ack. Read data
   // is random outside the ack cycle so a wrong sampling cycle shows up.
   initial begin
      mem.mem_ack   = 1'b0;
      mem.mem_rdata = 32'd0;
      forever begin
         @(negedge clk);
         if (mem.mem_req) begin
            mem.mem_ack = ((resp_delay >= 0) && (req_cycles == resp_delay)) || extra_ack;
            req_cycles++;
         end else begin
            mem.mem_ack = extra_ack;
            req_cycles  = 0;
         end
         mem.mem_rdata = mem.mem_ack ? resp_data : $urandom;
      end
   end

   // Pops the next queued expectation and checks it is the event seen.
   task automatic takeEvent(input int kind, output exp_t e, output bit ok);
      ok = 1'b0;
      e  = '{kind: -1, we: 1'b0, a: 32'd0, be: 4'd0, wdata: 32'd0, data: 32'd0};
      if (sb.size() == 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL unexpected_event: got kind %0d, want none", kind);
      end else begin
         e = sb.pop_front();
         checkOutput("event_kind", 32'(kind), 32'(e.kind));
         ok = (e.kind == kind);
      end
   endtask

   // Monitor: compares every new request, request-field stability while
   // the request is held, and each result pulse against the scoreboard.
   initial begin
      logic prev_req;
      exp_t cur;
      exp_t e;
      bit   ok;
      bit   have_cur;
      prev_req = 1'b0;
      have_cur = 1'b0;
      cur      = '{kind: 0, we: 1'b0, a: 32'd0, be: 4'd0, wdata: 32'd0, data: 32'd0};
      forever begin
         @(negedge clk);
         if (mem.mem_req === 1'b1 && !prev_req) begin
            takeEvent(K_REQ, e, ok);
            have_cur = ok;
            if (ok) begin
               cur = e;
               checkOutput("req_we", 32'(mem.mem_we), 32'(e.we));
               checkOutput("req_addr", mem.mem_addr, e.a);
               checkOutput("req_be", 32'(mem.mem_be), 32'(e.be));
               checkOutput("req_wdata", mem.mem_wdata, e.wdata);
            end
         end else if (mem.mem_req === 1'b1 && have_cur) begin
            checkOutput("hold_addr", mem.mem_addr, cur.a);
            checkOutput("hold_be", 32'(mem.mem_be), 32'(cur.be));
         end
         if (ld_valid === 1'b1) begin
            takeEvent(K_LOAD, e, ok);
            if (ok) checkOutput("ld_data", ld_data, e.data);
         end
         if (misalign === 1'b1) begin
            takeEvent(K_MIS, e, ok);
         end
         if (bus_err === 1'b1) begin
            takeEvent(K_BERR, e, ok);
            if (ok) checkOutput("ld_data_berr", ld_data, 32'd0);
         end
         prev_req = (mem.mem_req === 1'b1);
      end
   end

   // Main sequence: reset checks, the directed scenarios, a mid-access
   // reset, then a randomized stream of loads, stores and bubbles.
   initial begin
      exp_t        e;
      logic [31:0] r;
      logic [4:0]  lu;
      logic [31:0] a;
      int          d;

      $display("[TB] start");
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_mem_req", 32'(mem.mem_req), 32'd0);
      checkOutput("rst_mem_we", 32'(mem.mem_we), 32'd0);
      checkOutput("rst_mem_addr", mem.mem_addr, 32'd0);
      checkOutput("rst_mem_be", 32'(mem.mem_be), 32'd0);
      checkOutput("rst_mem_wdata", mem.mem_wdata, 32'd0);
      checkOutput("rst_ld_data", ld_data, 32'd0);
      checkOutput("rst_flags", {29'd0, ld_valid, misalign, bus_err}, 32'd0);
      checkOutput("rst_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      applyStimulus(5'b11010, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 1);
      applyStimulus(5'b10000, 32'h0000_0203, 32'd0, 32'h80FF_1234, 0);
      applyStimulus(5'b10100, 32'h0000_0203, 32'd0, 32'h80FF_1234, 0);
      applyStimulus(5'b11001, 32'h0000_0012, 32'h0000_ABCD, 32'd0, 0);
      applyStimulus(5'b10001, 32'h0000_0011, 32'd0, 32'd0, 0);
      applyStimulus(5'b10010, 32'h0000_0040, 32'd0, 32'h1234_5678, -1);
      applyStimulus(5'b10010, 32'h0000_0044, 32'd0, 32'hCAFE_F00D, TIMEOUT - 1);
      applyStimulus(5'b11100, 32'h0000_0000, 32'h1111_1111, 32'd0, 0);
      applyStimulus(5'b10011, 32'h0000_0000, 32'd0, 32'd0, 0);
      applyStimulus(5'b10101, 32'h0000_0022, 32'd0, 32'h8001_7FFF, 2);
      applyStimulus(5'b10001, 32'h0000_0002, 32'd0, 32'h8001_7FFF, 0);
      applyStimulus(5'b10010, 32'h0000_0000, 32'd0, 32'hA5A5_0F0F, 0);
      applyStimulus(5'b11010, 32'h0000_0004, 32'h0BAD_CAFE, 32'd0, 0);

      e = '{kind: K_REQ, we: 1'b0, a: 32'h0000_0020, be: 4'b1100, wdata: 32'd0, data: 32'd0};
      sb.push_back(e);
      resp_delay = -1;
      lsunit = 5'b10101;
      addr   = 32'h0000_0022;
      repeat (4) @(posedge clk);
      #1;
      rst_n  = 1'b0;
      lsunit = 5'd0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_mem_req", 32'(mem.mem_req), 32'd0);
      checkOutput("midreset_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      resp_data = 32'hFFFF_FFFF;
      extra_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      extra_ack = 1'b0;
      @(negedge clk);
      checkOutput("late_ack_ld_valid", 32'(ld_valid), 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(5'b11000, 32'h0000_0001, 32'h0000_00C3, 32'd0, 0);

      for (int n = 0; n < 150; n++) begin
         r  = $urandom;
         lu = {(r[3:0] != 4'd0), r[4], r[7:5]};
         a  = $urandom;
         if (r[8]) a[1:0] = 2'b00;
         r = $urandom_range(0, 11);
         if (r == 0) d = -1;
         else if (r == 1) d = TIMEOUT - 1;
         else d = int'($urandom_range(0, 3));
         applyStimulus(lu, a, $urandom, $urandom, d);
      end

      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
